oai33_cell_bist: RTL and testbench
==================================

Name: oai33_cell_bist

Overview:
- Built-in self-test stage that wraps one OAI33 cell (ZN = !((A1|A2|A3)&(B1|B2|B3))).
- Upstream half: an exhaustive pattern generator drives the cell's six inputs.
- Downstream half: captures the cell's ZN output and checks it against the expected function.
- Used on library test chips for functional silicon checkout; it reports pass/fail, an error count and the first failing vector.

Parameters:
- SETTLE_CYCLES, 2, wait cycles between driving a vector and sampling ZN; legal range 1..15.
- ERR_W, 7, width of the error counter; the counter saturates at its maximum value.

Ports:
- CLK  input  1  clock, rising edge.
- RN  input  1  synchronous active-low reset.
- START  input  1  starts a run; sampled only in IDLE or DONE.
- ZN  input  1  output of the OAI33 cell under test.
- A1, A2, A3, B1, B2, B3  output  1 each  registered drive to the cell under test.
- BUSY  output  1  high while a run is in progress.
- DONE  output  1  high from run completion until the next START or reset.
- PASS  output  1  valid when DONE=1; 1 if zero mismatches.
- ERR_CNT  output  ERR_W  count of mismatches, saturating.
- FAIL_VALID  output  1  high once a mismatch has been captured.
- FIRST_FAIL  output  6  vector index of the first mismatch.

Behaviour:
- Reset:
  - RN=0 at a rising CLK edge puts the block in IDLE.
  - All outputs go to 0, including the six drive pins, ERR_CNT and FIRST_FAIL.
  - Reset overrides any activity, including mid-run; there is no partial-result retention.
- Vector encoding: vec[5:0] = {B3,B2,B1,A3,A2,A1}, applied in ascending order 0..63.
- Expected value: exp = !((vec[0]|vec[1]|vec[2]) & (vec[3]|vec[4]|vec[5])).
- State machine: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
  - IDLE/DONE, START=1:
    - Clear DONE, PASS, ERR_CNT, FAIL_VALID and FIRST_FAIL.
    - Set vec=0, BUSY=1, go to DRIVE.
  - DRIVE: register vec onto the drive pins, load the settle counter with SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: decrement the counter; when it reaches 0, go to SAMPLE.
  - SAMPLE: compare ZN against exp using a 4-state compare (ZN X or Z counts as a mismatch).
    - On mismatch: ERR_CNT increments, saturating at 2^ERR_W-1.
    - If FAIL_VALID=0 at the mismatch: FIRST_FAIL=vec and FAIL_VALID=1.
    - If vec==63: go to DONE, set BUSY=0, DONE=1, PASS=(no mismatch in the run), and drive all pins to 0.
    - Otherwise: vec increments and the state returns to DRIVE.
- Timing:
  - Each vector takes SETTLE_CYCLES+2 cycles.
  - DONE rises at the edge 64*(SETTLE_CYCLES+2) cycles after the edge that sampled START (256 cycles for the default).
- START while BUSY=1 is ignored.
- START held high in DONE restarts immediately; the result outputs clear on that same edge.
- In DONE, ERR_CNT, FIRST_FAIL, FAIL_VALID and PASS hold until the next START or reset.

Optional Feature:
- Macro: OAI33_CELL_BIST_MISR_EN.
- When defined:
  - Adds output SIGNATURE [15:0], a CRC-CCITT LFSR (x^16+x^12+x^5+1).
  - SIGNATURE is seeded to 16'hFFFF on the START edge.
  - In every SAMPLE cycle it shifts in ZN, MSB-first feedback.
  - It holds in DONE and resets to 0 on RN.
- When not defined: the port and the logic are absent; all other behaviour is identical.

Test Plan:
- Ideal OAI33 model on ZN, SETTLE_CYCLES=2, START pulse -> BUSY=1 for 256 cycles; then DONE=1, PASS=1, ERR_CNT=0, FAIL_VALID=0.
- ZN stuck at 1 -> ERR_CNT=49, FIRST_FAIL=6'd9, FAIL_VALID=1, PASS=0.
- ZN stuck at 0 -> ERR_CNT=15, FIRST_FAIL=6'd0, PASS=0.
- ERR_W=4 with ZN stuck at 1 -> ERR_CNT saturates at 15, PASS=0.
- RN=0 at cycle 100 of a run; START pulse at cycle 50 of a second run:
  - After the reset edge: all outputs are 0 and the state is IDLE.
  - The mid-run START has no effect; DONE still rises at cycle 256 of the second run.
- With OAI33_CELL_BIST_MISR_EN, ideal ZN, then ZN forced inverted at vec 17 only:
  - The ideal run's SIGNATURE equals the bench's reference LFSR model.
  - The faulty run's SIGNATURE differs, with ERR_CNT=1 and FIRST_FAIL=6'd17.

Source files
------------

// File: rtl/oai33_cell_bist.sv
// -----------------------------------------------------------------------------
// oai33_cell_bist
//
// Built-in self-test wrapper for a single OAI33 cell (ZN = !((A1|A2|A3)&(B1|B2|B3))).
// An exhaustive generator walks vec = {B3,B2,B1,A3,A2,A1} from 0 to 63. Each
// vector is driven, allowed to settle for SETTLE_CYCLES, and then ZN is
// compared against the ideal function. The block reports pass/fail, a
// saturating mismatch count and the index of the first failing vector.
//
// Optional feature (macro OAI33_CELL_BIST_MISR_EN): adds SIGNATURE[15:0], a
// CRC-CCITT (x^16+x^12+x^5+1) signature of every sampled ZN, seeded to 16'hFFFF
// when a run starts.
//
// Ports:
//   CLK         in   rising-edge clock
//   RN          in   synchronous active-low reset
//   START       in   starts a run (honoured only when idle or done)
//   ZN          in   output of the cell under test
//   A1..B3      out  registered drive to the cell under test
//   BUSY        out  run in progress
//   DONE        out  run complete; held until next START or reset
//   PASS        out  valid with DONE; 1 when the run had no mismatch
//   ERR_CNT     out  saturating mismatch count
//   FAIL_VALID  out  a mismatch has been captured
//   FIRST_FAIL  out  vector index of the first mismatch
//   SIGNATURE   out  CRC signature (only with OAI33_CELL_BIST_MISR_EN)
//
// Parameters:
//   SETTLE_CYCLES  settle wait between drive and sample, legal range 1..15
//   ERR_W          width of the error counter
// -----------------------------------------------------------------------------
module oai33_cell_bist #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned ERR_W         = 7
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             START,
   input  logic             ZN,
   output logic             A1,
   output logic             A2,
   output logic             A3,
   output logic             B1,
   output logic             B2,
   output logic             B3,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [ERR_W-1:0] ERR_CNT,
   output logic             FAIL_VALID,
   output logic [5:0]       FIRST_FAIL
`ifdef OAI33_CELL_BIST_MISR_EN
   ,
   output logic [15:0]      SIGNATURE
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_e;

   // The settle counter counts down to zero and SAMPLE follows the cycle in
   // which it reads zero, so SETTLE lasts exactly SETTLE_CYCLES cycles.
   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_e             state_q, state_d;
   logic [5:0]         vec_q, vec_d;
   logic [5:0]         pins_q, pins_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               fail_valid_q, fail_valid_d;
   logic [5:0]         first_fail_q, first_fail_d;
`ifdef OAI33_CELL_BIST_MISR_EN
   logic [15:0]        sig_q, sig_d;
   logic               sig_fb;
`endif

   logic exp_zn;
   logic mismatch;

   assign exp_zn   = ~((vec_q[0] | vec_q[1] | vec_q[2]) & (vec_q[3] | vec_q[4] | vec_q[5]));
   // Case-inequality so an X or Z on ZN is scored as a mismatch.
   assign mismatch = (ZN !== exp_zn);

`ifdef OAI33_CELL_BIST_MISR_EN
   assign sig_fb = sig_q[15] ^ ZN;
`endif

   always_comb begin
      // NOTE: every _d starts as its _q so no branch can leave it unassigned and infer a latch.
      state_d      = state_q;
      vec_d        = vec_q;
      pins_d       = pins_q;
      cnt_d        = cnt_q;
      busy_d       = busy_q;
      done_d       = done_q;
      pass_d       = pass_q;
      err_d        = err_q;
      fail_valid_d = fail_valid_q;
      first_fail_d = first_fail_q;
`ifdef OAI33_CELL_BIST_MISR_EN
      sig_d        = sig_q;
`endif

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               state_d      = ST_DRIVE;
               vec_d        = 6'd0;
               busy_d       = 1'b1;
               done_d       = 1'b0;
               pass_d       = 1'b0;
               err_d        = '0;
               fail_valid_d = 1'b0;
               first_fail_d = 6'd0;
`ifdef OAI33_CELL_BIST_MISR_EN
               sig_d        = 16'hFFFF;
`endif
            end
         end

         ST_DRIVE: begin
            pins_d  = vec_q;
            cnt_d   = CNT_LOAD;
            state_d = ST_SETTLE;
         end

         ST_SETTLE: begin
            if (cnt_q == 4'd0) state_d = ST_SAMPLE;
            else               cnt_d   = cnt_q - 4'd1;
         end

         ST_SAMPLE: begin
            if (mismatch) begin
               if (err_q != '1) err_d = err_q + 1'b1;
               if (!fail_valid_q) begin
                  fail_valid_d = 1'b1;
                  first_fail_d = vec_q;
               end
            end
`ifdef OAI33_CELL_BIST_MISR_EN
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_fb ? 16'h1021 : 16'h0000);
`endif
            if (vec_q == 6'd63) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               // The current sample has not reached fail_valid_q yet.
               pass_d  = ~fail_valid_q & ~mismatch;
               pins_d  = 6'd0;
            end else begin
               vec_d   = vec_q + 6'd1;
               state_d = ST_DRIVE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      // NOTE: reset is synchronous; RN only takes effect on a rising CLK edge.
      if (!RN) begin
         state_q      <= ST_IDLE;
         vec_q        <= 6'd0;
         pins_q       <= 6'd0;
         cnt_q        <= 4'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_q        <= '0;
         fail_valid_q <= 1'b0;
         first_fail_q <= 6'd0;
`ifdef OAI33_CELL_BIST_MISR_EN
         sig_q        <= 16'h0000;
`endif
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values together.
         state_q      <= state_d;
         vec_q        <= vec_d;
         pins_q       <= pins_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         err_q        <= err_d;
         fail_valid_q <= fail_valid_d;
         first_fail_q <= first_fail_d;
`ifdef OAI33_CELL_BIST_MISR_EN
         sig_q        <= sig_d;
`endif
      end
   end

   assign {B3, B2, B1, A3, A2, A1} = pins_q;
   assign BUSY       = busy_q;
   assign DONE       = done_q;
   assign PASS       = pass_q;
   assign ERR_CNT    = err_q;
   assign FAIL_VALID = fail_valid_q;
   assign FIRST_FAIL = first_fail_q;
`ifdef OAI33_CELL_BIST_MISR_EN
   assign SIGNATURE  = sig_q;
`endif

endmodule

// File: tb/tb_oai33_cell_bist.sv
// -----------------------------------------------------------------------------
// tb_oai33_cell_bist
//
// Directed bench for oai33_cell_bist. A behavioural cell model drives ZN from
// the DUT's pins in one of several modes (ideal, stuck-at, single-vector
// fault). A second instance with ERR_W=4 and ZN tied high covers counter
// saturation. The MISR scenario is included when OAI33_CELL_BIST_MISR_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_oai33_cell_bist;

   localparam int LIMIT = 1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rn, start, zn;
   logic       a1, a2, a3, b1, b2, b3;
   logic       busy, done, pass, fail_valid;
   logic [6:0] err_cnt;
   logic [5:0] first_fail;

   logic       start_s;
   logic       a1_s, a2_s, a3_s, b1_s, b2_s, b3_s;
   logic       busy_s, done_s, pass_s, fail_valid_s;
   logic [3:0] err_cnt_s;
   logic [5:0] first_fail_s;

`ifdef OAI33_CELL_BIST_MISR_EN
   logic [15:0] signature, signature_s;
`endif

   int checks = 0;
   int errors = 0;

   // 0 ideal, 1 stuck-at-1, 2 stuck-at-0, 3 ideal but inverted at vector 17
   int mode = 0;

   logic [5:0] pv;
   assign pv = {b3, b2, b1, a3, a2, a1};

   function automatic logic oai33(input logic [5:0] v);
      return ~((v[0] | v[1] | v[2]) & (v[3] | v[4] | v[5]));
   endfunction

   always_comb begin
      case (mode)
         1:       zn = 1'b1;
         2:       zn = 1'b0;
         3:       zn = oai33(pv) ^ (pv == 6'd17);
         default: zn = oai33(pv);
      endcase
   end

   oai33_cell_bist dut (
      .CLK(clk), .RN(rn), .START(start), .ZN(zn),
      .A1(a1), .A2(a2), .A3(a3), .B1(b1), .B2(b2), .B3(b3),
      .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err_cnt),
      .FAIL_VALID(fail_valid), .FIRST_FAIL(first_fail)
`ifdef OAI33_CELL_BIST_MISR_EN
      , .SIGNATURE(signature)
`endif
   );

   oai33_cell_bist #(.SETTLE_CYCLES(2), .ERR_W(4)) dut_sat (
      .CLK(clk), .RN(rn), .START(start_s), .ZN(1'b1),
      .A1(a1_s), .A2(a2_s), .A3(a3_s), .B1(b1_s), .B2(b2_s), .B3(b3_s),
      .BUSY(busy_s), .DONE(done_s), .PASS(pass_s), .ERR_CNT(err_cnt_s),
      .FAIL_VALID(fail_valid_s), .FIRST_FAIL(first_fail_s)
`ifdef OAI33_CELL_BIST_MISR_EN
      , .SIGNATURE(signature_s)
`endif
   );

   // One-cycle START pulse; returns half a cycle after the sampling edge.
   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Counts rising edges until DONE, bounded by LIMIT.
   task automatic wait_done(output int cycles, output bit busy_gap);
      cycles   = 0;
      busy_gap = 1'b0;
      do begin
         @(posedge clk); #1;
         cycles++;
         if (!done && !busy) busy_gap = 1'b1;
      end while (!done && cycles < LIMIT);
   endtask

   task automatic test_reset();
      rn = 1'b0; start = 1'b0; start_s = 1'b0; mode = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, pass, fail_valid, err_cnt, first_fail, pv} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b pass=%b fv=%b err=%0d ff=%0d pins=%b, want all 0",
                  busy, done, pass, fail_valid, err_cnt, first_fail, pv);
      end
      @(negedge clk) rn = 1'b1;
   endtask

   task automatic test_ideal();
      int cyc; bit gap;
      mode = 0;
      pulse_start();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL ideal_busy_start: got %b want 1", busy); end
      wait_done(cyc, gap);
      checks++;
      if (cyc != 256 || gap) begin errors++; $display("FAIL ideal_latency: got %0d cycles gap=%b want 256 gap=0", cyc, gap); end
      checks++;
      if ({done, busy, pass, fail_valid, err_cnt} !== {1'b1, 1'b0, 1'b1, 1'b0, 7'd0}) begin
         errors++;
         $display("FAIL ideal_result: got done=%b busy=%b pass=%b fv=%b err=%0d want 1 0 1 0 0", done, busy, pass, fail_valid, err_cnt);
      end
      checks++;
      if (pv !== 6'd0) begin errors++; $display("FAIL ideal_pins_idle: got %b want 000000", pv); end
   endtask

   task automatic test_stuck1();
      int cyc; bit gap;
      mode = 1;
      pulse_start();
      wait_done(cyc, gap);
      checks++;
      if (cyc != 256) begin errors++; $display("FAIL stuck1_latency: got %0d want 256", cyc); end
      checks++;
      if ({pass, fail_valid, err_cnt, first_fail} !== {1'b0, 1'b1, 7'd49, 6'd9}) begin
         errors++;
         $display("FAIL stuck1_result: got pass=%b fv=%b err=%0d ff=%0d want 0 1 49 9", pass, fail_valid, err_cnt, first_fail);
      end
      // Results must hold in DONE while START stays low.
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if ({done, err_cnt, first_fail} !== {1'b1, 7'd49, 6'd9}) begin
         errors++;
         $display("FAIL stuck1_hold: got done=%b err=%0d ff=%0d want 1 49 9", done, err_cnt, first_fail);
      end
   endtask

   // Restart directly from DONE: results clear on the START edge itself.
   task automatic test_back_to_back();
      int cyc; bit gap;
      mode = 0;
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({done, busy, pass, fail_valid, err_cnt, first_fail} !== {1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 6'd0}) begin
         errors++;
         $display("FAIL b2b_clear: got done=%b busy=%b pass=%b fv=%b err=%0d ff=%0d want 0 1 0 0 0 0",
                  done, busy, pass, fail_valid, err_cnt, first_fail);
      end
      wait_done(cyc, gap);
      checks++;
      if (cyc != 256 || pass !== 1'b1) begin errors++; $display("FAIL b2b_run: got %0d cycles pass=%b want 256 1", cyc, pass); end
   endtask

   task automatic test_stuck0();
      int cyc; bit gap;
      mode = 2;
      pulse_start();
      wait_done(cyc, gap);
      checks++;
      if ({pass, fail_valid, err_cnt, first_fail} !== {1'b0, 1'b1, 7'd15, 6'd0}) begin
         errors++;
         $display("FAIL stuck0_result: got pass=%b fv=%b err=%0d ff=%0d want 0 1 15 0", pass, fail_valid, err_cnt, first_fail);
      end
   endtask

   task automatic test_saturate();
      int cyc;
      @(negedge clk) start_s = 1'b1;
      @(negedge clk) start_s = 1'b0;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!done_s && cyc < LIMIT);
      checks++;
      if (cyc != 256) begin errors++; $display("FAIL sat_latency: got %0d want 256", cyc); end
      checks++;
      if ({pass_s, fail_valid_s, err_cnt_s, first_fail_s} !== {1'b0, 1'b1, 4'd15, 6'd9}) begin
         errors++;
         $display("FAIL sat_result: got pass=%b fv=%b err=%0d ff=%0d want 0 1 15 9", pass_s, fail_valid_s, err_cnt_s, first_fail_s);
      end
   endtask

   task automatic test_reset_midrun();
      int cyc;
      mode = 1;
      pulse_start();
      repeat (99) @(posedge clk);
      @(negedge clk) rn = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy, done, pass, fail_valid, err_cnt, first_fail, pv} !== '0) begin
         errors++;
         $display("FAIL midrun_reset: got busy=%b done=%b pass=%b fv=%b err=%0d ff=%0d pins=%b want all 0",
                  busy, done, pass, fail_valid, err_cnt, first_fail, pv);
      end
      @(negedge clk) rn = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, pv} !== '0) begin
         errors++;
         $display("FAIL midrun_idle: got busy=%b done=%b pins=%b want 0 0 0", busy, done, pv);
      end

      // Second run with a stray START at cycle 50; completion must not move.
      mode = 0;
      pulse_start();
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         start = (cyc == 49);
      end while (!done && cyc < LIMIT);
      start = 1'b0;
      checks++;
      if (cyc != 256 || pass !== 1'b1 || err_cnt !== 7'd0) begin
         errors++;
         $display("FAIL midrun_start_ignored: got %0d cycles pass=%b err=%0d want 256 1 0", cyc, pass, err_cnt);
      end
   endtask

`ifdef OAI33_CELL_BIST_MISR_EN
   function automatic logic [15:0] misr_ref(input int fault_vec);
      logic [15:0] s;
      logic        z, fb;
      s = 16'hFFFF;
      for (int v = 0; v < 64; v++) begin
         z  = oai33(6'(v)) ^ (v == fault_vec);
         fb = s[15] ^ z;
         s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return s;
   endfunction

   task automatic test_misr();
      int cyc; bit gap;
      logic [15:0] good_sig;
      mode = 0;
      pulse_start();
      wait_done(cyc, gap);
      good_sig = signature;
      checks++;
      if (signature !== misr_ref(-1)) begin
         errors++;
         $display("FAIL misr_ideal: got %h want %h", signature, misr_ref(-1));
      end
      mode = 3;
      pulse_start();
      wait_done(cyc, gap);
      checks++;
      if (signature === good_sig || signature !== misr_ref(17)) begin
         errors++;
         $display("FAIL misr_fault: got %h want %h (ideal %h)", signature, misr_ref(17), good_sig);
      end
      checks++;
      if ({pass, err_cnt, first_fail, fail_valid} !== {1'b0, 7'd1, 6'd17, 1'b1}) begin
         errors++;
         $display("FAIL misr_fault_result: got pass=%b err=%0d ff=%0d fv=%b want 0 1 17 1", pass, err_cnt, first_fail, fail_valid);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_ideal();
      test_stuck1();
      test_back_to_back();
      test_stuck0();
      test_saturate();
      test_reset_midrun();
`ifdef OAI33_CELL_BIST_MISR_EN
      test_misr();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
